// File: rtl/mem_port_arbiter.sv
// Memory port arbiter. A cache refill port and a write-buffer drain port
// share one main-memory port. At most one memory transaction is outstanding.
// Reads normally win. A write wins when it targets the same line as the
// pending read, or when reads have starved a waiting write long enough.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LINE_WIDTH-1:0] rd_data,
    output logic                  rd_done,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [LINE_WIDTH-1:0] wb_data,
    output logic                  wb_pop,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    // Byte-offset bits within a line; these are ignored when comparing addresses.
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_done_q, rd_done_d;
    logic                  wb_pop_q, wb_pop_d;
    logic [SW-1:0]         starve_cnt_q, starve_cnt_d;

    logic line_match;
    logic settling;

    assign line_match = (rd_addr[ADDR_WIDTH-1:OFF_W] == wb_addr[ADDR_WIDTH-1:OFF_W]);
    // A completion pulse marks the first IDLE cycle; no grant is made in it.
    assign settling   = rd_done_q | wb_pop_q;

    // Next-state, grant decision and output register updates.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_data_d    = rd_data_q;
        rd_done_d    = 1'b0;
        wb_pop_d     = 1'b0;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                if (!settling) begin
                    if ((rd_req && wb_valid && line_match) ||
                        (wb_valid && (!rd_req || starve_cnt_q == STARVE_LIM))) begin
                        // Same-line conflict (read-after-write) or starved write.
                        state_d      = WR_BUSY;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wb_addr;
                        mem_wdata_d  = wb_data;
                        starve_cnt_d = '0;
                    end else if (rd_req) begin
                        state_d    = RD_BUSY;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = rd_addr;
                        if (wb_valid && starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + SW'(1);
                        end
                    end
                end
            end
            RD_BUSY: begin
                if (mem_ack) begin
                    rd_data_d = mem_rdata;
                    rd_done_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WR_BUSY: begin
                if (mem_ack) begin
                    wb_pop_d  = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // Starvation only matters while a write is actually waiting.
        if (!wb_valid) begin
            starve_cnt_d = '0;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            rd_done_q    <= 1'b0;
            wb_pop_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_done_q    <= rd_done_d;
            wb_pop_q     <= wb_pop_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_done   = rd_done_q;
    assign wb_pop    = wb_pop_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 128, meaning cacheline width in bits.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive read grants allowed while a write is pending.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port rd_req, input, 1, meaning cache refill request, held until rd_done.
REQ-007 The block SHALL have port rd_addr, input, ADDR_WIDTH, meaning refill line address, stable while rd_req is high.
REQ-008 The block SHALL have port rd_data, output, LINE_WIDTH, meaning the refill line returned.
REQ-009 The block SHALL have port rd_done, output, 1, meaning a one-cycle pulse that marks rd_data valid.
REQ-010 The block SHALL have port wb_valid, input, 1, meaning the write buffer head entry is valid.
REQ-011 The block SHALL have port wb_addr, input, ADDR_WIDTH, meaning the head entry line address.
REQ-012 The block SHALL have port wb_data, input, LINE_WIDTH, meaning the head entry line data.
REQ-013 The block SHALL have port wb_pop, output, 1, meaning a one-cycle pulse that retires the head entry.
REQ-014 The block SHALL have port mem_req, output, 1, meaning main memory request.
REQ-015 The block SHALL have port mem_we, output, 1, meaning 1 for write and 0 for read.
REQ-016 The block SHALL have port mem_addr, output, ADDR_WIDTH, meaning the memory line address.
REQ-017 The block SHALL have port mem_wdata, output, LINE_WIDTH, meaning the memory write line.
REQ-018 The block SHALL have port mem_ack, input, 1, meaning memory has completed the current request (read data valid on mem_rdata).
REQ-019 The block SHALL have port mem_rdata, input, LINE_WIDTH, meaning the memory read line.

Function
REQ-020 The FSM SHALL have states IDLE, RD_BUSY and WR_BUSY; there SHALL be at most one outstanding memory transaction.
REQ-021 In IDLE, with no conflict, a pending rd_req SHALL win over wb_valid unless starve_cnt == STARVE_MAX.
REQ-022 Conflict: when rd_req && wb_valid && the wb_addr and rd_addr line bits match (offset ignored), the write SHALL be granted first (RAW protection).
REQ-023 On a grant, the block SHALL register the address and data into mem_addr/mem_wdata, drive mem_req=1 and set mem_we for the next cycle, and enter RD_BUSY or WR_BUSY.
REQ-024 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack.
REQ-025 In RD_BUSY, on mem_ack the block SHALL register mem_rdata into rd_data, pulse rd_done for 1 cycle, drop mem_req, and return to IDLE.
REQ-026 In WR_BUSY, on mem_ack the block SHALL pulse wb_pop for 1 cycle, drop mem_req, and return to IDLE.
REQ-027 The block SHALL grant nothing in the cycle it returns to IDLE; minimum spacing is 1 idle cycle between transactions.
REQ-028 The block SHALL ignore a mem_ack that arrives while in IDLE.
REQ-029 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on each read grant made while wb_valid=1, saturate at STARVE_MAX, and clear on any write grant or whenever wb_valid=0.
REQ-030 rd_data SHALL hold its last value until the next read completion.
REQ-031 Request latency SHALL be: grant at edge N, mem_req high from N+1, rd_done/wb_pop one cycle after the mem_ack edge.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, mem_req=0, mem_we=0, rd_done=0, wb_pop=0, starve_cnt=0, and mem_addr, mem_wdata and rd_data to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction, with no rd_done and no wb_pop; requesters re-issue after release.
REQ-034 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge.

Verification
REQ-035 Read only: rd_req=1, rd_addr=0x100, mem_ack 3 cycles after mem_req -> mem_we=0, mem_addr=0x100, and rd_done pulses once with rd_data=mem_rdata.
REQ-036 Write only: wb_valid=1, wb_addr=0x200, wb_data=0xA5..A5 -> mem_we=1, mem_wdata=0xA5..A5, and one wb_pop pulse after mem_ack.
REQ-037 Simultaneous requests with no conflict: rd 0x100, wb 0x300 -> read served first, then the write.
REQ-038 RAW conflict: rd_addr=0x104, wb_addr=0x100 (same line) -> write served first, then the read.
REQ-039 Starvation: wb_valid held and rd_req reasserted continuously -> after 4 reads the 5th grant is the write and starve_cnt returns to 0.
REQ-040 Reset in RD_BUSY: rst pulsed before mem_ack -> mem_req=0 at once, no rd_done, and a later mem_ack is ignored.
